// File: rtl/alu.sv
// 32-bit MIPS EX-stage ALU: combinational result and N/Z/V flags, plus a
// registered copy of the flags (NQ/ZQ/VQ) for logic that consumes them a cycle later.
module alu #(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [3:0]        ALUOP,
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    output logic [WORD_W-1:0] O,
    output logic              N,
    output logic              Z,
    output logic              V,
    output logic              NQ,
    output logic              ZQ,
    output logic              VQ
);

    localparam int SH_W = $clog2(WORD_W);

    typedef enum logic [3:0] {
        OP_SLL  = 4'b0000,
        OP_SRL  = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0011,
        OP_AND  = 4'b0100,
        OP_OR   = 4'b0101,
        OP_XOR  = 4'b0110,
        OP_NOR  = 4'b0111,
        OP_SLT  = 4'b1010,
        OP_SLTU = 4'b1011
    } aluop_t;

    logic [SH_W-1:0]   w_shamt;
    logic [WORD_W-1:0] w_sum;
    logic [WORD_W-1:0] w_diff;
    logic              w_slt;
    logic              w_sltu;
    logic [WORD_W-1:0] w_result;
    logic              w_ovf;

    logic              r_nq;
    logic              r_zq;
    logic              r_vq;

    // Only the low bits of B select the shift distance; the rest are ignored.
    assign w_shamt = B[SH_W-1:0];
    assign w_sum   = A + B;
    assign w_diff  = A - B;
    assign w_slt   = ($signed(A) < $signed(B));
    assign w_sltu  = (A < B);

    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        case (ALUOP)
            OP_SLL:  w_result = A << w_shamt;
            OP_SRL:  w_result = A >> w_shamt;
            OP_ADD: begin
                w_result = w_sum;
                w_ovf    = (A[WORD_W-1] == B[WORD_W-1]) && (w_sum[WORD_W-1] != A[WORD_W-1]);
            end
            OP_SUB: begin
                w_result = w_diff;
                w_ovf    = (A[WORD_W-1] != B[WORD_W-1]) && (w_diff[WORD_W-1] != A[WORD_W-1]);
            end
            OP_AND:  w_result = A & B;
            OP_OR:   w_result = A | B;
            OP_XOR:  w_result = A ^ B;
            OP_NOR:  w_result = ~(A | B);
            OP_SLT:  w_result = {{(WORD_W-1){1'b0}}, w_slt};
            OP_SLTU: w_result = {{(WORD_W-1){1'b0}}, w_sltu};
            default: w_result = '0;
        endcase
    end

    assign O = w_result;
    assign N = w_result[WORD_W-1];
    assign Z = (w_result == '0);
    assign V = w_ovf;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_nq <= 1'b0;
            r_zq <= 1'b0;
            r_vq <= 1'b0;
        end else begin
            r_nq <= N;
            r_zq <= Z;
            r_vq <= V;
        end
    end

    assign NQ = r_nq;
    assign ZQ = r_zq;
    assign VQ = r_vq;

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed boundary cases plus randomized operands checked
// against an arithmetic reference model; also exercises the registered flags.
module tb_alu;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [3:0]  ALUOP = 4'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [31:0] O;
    logic        N, Z, V, NQ, ZQ, VQ;

    int passed = 0;
    int total  = 0;

    localparam logic [3:0] SLL  = 4'b0000;
    localparam logic [3:0] SRL  = 4'b0001;
    localparam logic [3:0] ADD  = 4'b0010;
    localparam logic [3:0] SUB  = 4'b0011;
    localparam logic [3:0] ANDO = 4'b0100;
    localparam logic [3:0] SLT  = 4'b1010;
    localparam logic [3:0] SLTU = 4'b1011;

    alu dut (
        .CLK  (CLK),
        .nRST (nRST),
        .ALUOP(ALUOP),
        .A    (A),
        .B    (B),
        .O    (O),
        .N    (N),
        .Z    (Z),
        .V    (V),
        .NQ   (NQ),
        .ZQ   (ZQ),
        .VQ   (VQ)
    );

    always #5 CLK = ~CLK;

    // Reference model: shifts as multiply/divide by powers of two, overflow
    // from 64-bit signed arithmetic leaving the 32-bit range.
    function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] o,
                                  output logic n, output logic z, output logic v);
        longint sa;
        longint sb;
        longint r;
        logic [63:0] p;
        logic [4:0]  sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = b[4:0];
        o = 32'd0;
        v = 1'b0;
        r = 0;
        case (op)
            4'd0: begin p = {32'd0, a} * (64'd1 << sh); o = p[31:0]; end
            4'd1: o = a / (32'd1 << sh);
            4'd2: begin
                r = sa + sb; o = r[31:0];
                v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            4'd3: begin
                r = sa - sb; o = r[31:0];
                v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            4'd4: o = a & b;
            4'd5: o = a | b;
            4'd6: o = a ^ b;
            4'd7: o = ~(a | b);
            4'd10: o = (sa < sb) ? 32'd1 : 32'd0;
            4'd11: o = (a < b) ? 32'd1 : 32'd0;
            default: o = 32'd0;
        endcase
        n = o[31];
        z = (o == 32'd0);
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        ALUOP = op;
        A     = a;
        B     = b;
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        drive(ADD, 32'd0, 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        total++;
        if ({NQ, ZQ, VQ} !== 3'b000) $display("FAIL reset_flags_zero: got %b required 000", {NQ, ZQ, VQ});
        else passed++;
        total++;
        if (Z !== 1'b1) $display("FAIL reset_z_tracks: got %b required 1", Z);
        else passed++;
        drive(SUB, 32'h8000_0000, 32'd1);
        @(posedge CLK);
        #1;
        total++;
        if (V !== 1'b1 || VQ !== 1'b0) $display("FAIL reset_vq_held: V=%b VQ=%b required V=1 VQ=0", V, VQ);
        else passed++;
    endtask

    task automatic test_flags_reg();
        logic [31:0] eo;
        logic en, ez, ev;
        @(negedge CLK);
        nRST = 1'b1;
        drive(SUB, 32'd9, 32'd9);
        @(posedge CLK);
        #1;
        total++;
        if (ZQ !== 1'b1) $display("FAIL flags_zq_load: got %b required 1", ZQ);
        else passed++;
        #2;
        nRST = 1'b0;
        #1;
        total++;
        if (ZQ !== 1'b0) $display("FAIL flags_async_clear: got %b required 0", ZQ);
        else passed++;
        @(negedge CLK);
        nRST = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            drive(4'($urandom_range(0, 11)), $urandom, $urandom);
            model(ALUOP, A, B, eo, en, ez, ev);
            @(posedge CLK);
            #1;
            total++;
            if ({NQ, ZQ, VQ} !== {en, ez, ev})
                $display("FAIL flags_reg_rand op=%0d: got %b required %b", ALUOP, {NQ, ZQ, VQ}, {en, ez, ev});
            else passed++;
        end
    endtask

    task automatic test_shifts();
        logic [3:0]  ops [7] = '{SLL, SRL, SLL, SRL, SLL, SRL, SLL};
        logic [31:0] as  [7] = '{32'h1, 32'h8000_0000, 32'hDEAD_BEEF, 32'h1234_5678,
                                 32'h1, 32'h8000_0000, 32'h3};
        logic [31:0] bs  [7] = '{32'd5, 32'd4, 32'd0, 32'hFFFF_FFE0,
                                 32'd31, 32'd31, 32'hFFFF_FF21};
        logic [31:0] es  [7] = '{32'h20, 32'h0800_0000, 32'hDEAD_BEEF, 32'h1234_5678,
                                 32'h8000_0000, 32'h1, 32'h6};
        for (int i = 0; i < 7; i++) begin
            drive(ops[i], as[i], bs[i]);
            total++;
            if (O !== es[i]) $display("FAIL shift_%0d: got %h required %h", i, O, es[i]);
            else passed++;
        end
    endtask

    task automatic test_arith();
        drive(SUB, 32'd2, 32'd4);
        total++;
        if (O !== 32'hFFFF_FFFE || N !== 1'b1) $display("FAIL sub_neg: O=%h N=%b required FFFFFFFE 1", O, N);
        else passed++;
        drive(ADD, 32'd2, 32'd4);
        total++;
        if (O !== 32'd6 || N !== 1'b0) $display("FAIL add_pos: O=%h N=%b required 6 0", O, N);
        else passed++;
        drive(SUB, 32'd9, 32'd9);
        total++;
        if (Z !== 1'b1) $display("FAIL sub_zero: Z=%b required 1", Z);
        else passed++;
        drive(ADD, 32'd9, 32'd9);
        total++;
        if (O !== 32'd18 || Z !== 1'b0) $display("FAIL add_nonzero: O=%h Z=%b required 12 0", O, Z);
        else passed++;
    endtask

    task automatic test_overflow();
        drive(ADD, 32'h8000_0000, 32'h8000_0000);
        total++;
        if (O !== 32'd0 || V !== 1'b1 || Z !== 1'b1) $display("FAIL add_ovf_neg: O=%h V=%b Z=%b required 0 1 1", O, V, Z);
        else passed++;
        drive(SUB, 32'h8000_0000, 32'h7FFF_FFFF);
        total++;
        if (V !== 1'b1) $display("FAIL sub_ovf: V=%b required 1", V);
        else passed++;
        drive(ADD, 32'd10, 32'd10);
        total++;
        if (V !== 1'b0) $display("FAIL add_no_ovf: V=%b required 0", V);
        else passed++;
        drive(SUB, 32'h8000_0000, 32'd1);
        total++;
        if (O !== 32'h7FFF_FFFF || V !== 1'b1) $display("FAIL sub_min_minus1: O=%h V=%b required 7FFFFFFF 1", O, V);
        else passed++;
        drive(ADD, 32'h7FFF_FFFF, 32'd1);
        total++;
        if (O !== 32'h8000_0000 || V !== 1'b1 || N !== 1'b1) $display("FAIL add_max_plus1: O=%h V=%b N=%b required 80000000 1 1", O, V, N);
        else passed++;
        drive(ANDO, 32'h8000_0000, 32'h8000_0000);
        total++;
        if (V !== 1'b0 || N !== 1'b1) $display("FAIL logic_v_zero: V=%b N=%b required 0 1", V, N);
        else passed++;
    endtask

    task automatic test_compare();
        drive(SLT, 32'hFFFF_FFFF, 32'd1);
        total++;
        if (O !== 32'd1) $display("FAIL slt_signed: got %h required 1", O);
        else passed++;
        drive(SLTU, 32'hFFFF_FFFF, 32'd1);
        total++;
        if (O !== 32'd0) $display("FAIL sltu_unsigned: got %h required 0", O);
        else passed++;
        drive(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        total++;
        if (O !== 32'd0 || {N, Z, V} !== 3'b010) $display("FAIL undef_op: O=%h NZV=%b required 0 010", O, {N, Z, V});
        else passed++;
    endtask

    task automatic test_logic_random();
        logic [31:0] eo;
        logic en, ez, ev;
        for (int i = 0; i < 10; i++) begin
            A = $urandom;
            B = $urandom;
            for (int k = 4; k < 8; k++) begin
                drive(4'(k), A, B);
                model(ALUOP, A, B, eo, en, ez, ev);
                total++;
                if (O !== eo || N !== en || Z !== ez)
                    $display("FAIL logic_rand op=%0d a=%h b=%h: got %h %b%b required %h %b%b", k, A, B, O, N, Z, eo, en, ez);
                else passed++;
            end
        end
    endtask

    task automatic test_random_all();
        logic [31:0] eo;
        logic en, ez, ev;
        for (int i = 0; i < 60; i++) begin
            drive(4'($urandom_range(0, 15)), $urandom, (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom);
            model(ALUOP, A, B, eo, en, ez, ev);
            total++;
            if (O !== eo || {N, Z, V} !== {en, ez, ev})
                $display("FAIL all_rand op=%0d a=%h b=%h: got %h %b required %h %b", ALUOP, A, B, O, {N, Z, V}, eo, {en, ez, ev});
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_flags_reg();
        test_shifts();
        test_arith();
        test_overflow();
        test_compare();
        test_logic_random();
        test_random_all();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
